// File: rtl/reset_sequencer_pkg.sv
// reset_sequencer_pkg: shared types and helpers for the board reset sequencer.
//   state_e      - FSM state encoding (values are visible on oSTATE)
//   CntWDefault  - default width of the shared delay/timeout counter
//   idx_width()  - bits needed to hold a stage index
package reset_sequencer_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StHold   = 3'd1,
    StRel    = 3'd2,
    StSettle = 3'd3,
    StDone   = 3'd4,
    StFault  = 3'd5
  } state_e;

  localparam int unsigned CntWDefault = 20;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/reset_sequencer_if.sv
// reset_sequencer_if: status/handshake bundle between the sequencer and the board.
//   iSTART     - power-on timer done level (1 = supplies stable)
//   iREADY     - per-stage ready/ack level, bit k = stage k
//   oSTAGE_RST - per-stage active-high reset, bit k = stage k
//   oDONE      - all stages released and ready
//   oERROR     - sticky timeout / loss-of-ready flag
//   oSTATE     - current sequencer state, for debug
// master: the board side driving start/ready; slave: the sequencer.
interface reset_sequencer_if #(
  parameter int unsigned NUM_STAGES = 3
);

  logic                  iSTART;
  logic [NUM_STAGES-1:0] iREADY;
  logic [NUM_STAGES-1:0] oSTAGE_RST;
  logic                  oDONE;
  logic                  oERROR;
  logic [2:0]            oSTATE;

  modport master (
    output iSTART, iREADY,
    input  oSTAGE_RST, oDONE, oERROR, oSTATE
  );

  modport slave (
    input  iSTART, iREADY,
    output oSTAGE_RST, oDONE, oERROR, oSTATE
  );

endinterface

// File: rtl/reset_sequencer_delay_counter.sv
// reset_sequencer_delay_counter: shared up-counter for hold, settle and timeout intervals.
//   iCLK, iRST - clock and synchronous active-high reset
//   i_clr      - clear to zero (wins over i_en)
//   i_en       - increment by one
//   i_term     - terminal value to compare against
//   o_tc       - count currently equals i_term
module reset_sequencer_delay_counter
  import reset_sequencer_pkg::*;
#(
  parameter int unsigned CNT_W = CntWDefault
) (
  input  logic             iCLK,
  input  logic             iRST,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic [CNT_W-1:0] i_term,
  output logic             o_tc
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge iCLK) begin
    if (iRST || i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_tc = (r_cnt == i_term);

endmodule

// File: rtl/reset_sequencer.sv
// reset_sequencer: releases subsystem resets one stage at a time after power-on.
//   iCLK, iRST - clock and synchronous active-high reset
//   bus        - slave side of reset_sequencer_if (start/ready in, resets/status out)
// Every stage stays in reset for HOLD_CYCLES after start, then stages are released in
// order; each must raise ready within TIMEOUT_CYCLES and is followed by SETTLE_CYCLES
// before the next release. Timeout or ready loss after completion parks in a sticky fault.
module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int unsigned NUM_STAGES     = 3,
  parameter int unsigned CNT_W          = CntWDefault,
  parameter int unsigned HOLD_CYCLES    = 32'h000F_FFFF,
  parameter int unsigned SETTLE_CYCLES  = 32'd1024,
  parameter int unsigned TIMEOUT_CYCLES = 32'h000F_FFFF
) (
  input logic                iCLK,
  input logic                iRST,
  reset_sequencer_if.slave   bus
);

  localparam int unsigned      IdxW        = idx_width(NUM_STAGES);
  localparam logic [CNT_W-1:0] HoldTerm    = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] SettleTerm  = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TimeoutTerm = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [IdxW-1:0]  LastIdx     = IdxW'(NUM_STAGES - 1);

  state_e                r_state;
  logic [IdxW-1:0]       r_idx;
  logic [NUM_STAGES-1:0] r_stage_rst;
  logic                  r_done;
  logic                  r_error;

  logic                  w_tc;
  logic                  w_cnt_clr;
  logic                  w_cnt_en;
  logic [CNT_W-1:0]      w_term;
  logic                  w_ready_cur;
  logic [IdxW-1:0]       w_idx_next;
  logic [NUM_STAGES-1:0] w_next_mask;

  assign w_idx_next = r_idx + 1'b1;

  // Decoded by loop so a non-power-of-two stage count never indexes out of range.
  always_comb begin
    w_ready_cur = 1'b0;
    w_next_mask = '0;
    for (int unsigned k = 0; k < NUM_STAGES; k++) begin
      if (IdxW'(k) == r_idx)      w_ready_cur    = bus.iREADY[k];
      if (IdxW'(k) == w_idx_next) w_next_mask[k] = 1'b1;
    end
  end

  // One counter serves all timed states; the terminal value follows the state.
  always_comb begin
    w_cnt_clr = 1'b1;
    w_cnt_en  = 1'b0;
    w_term    = '0;
    if (bus.iSTART) begin
      case (r_state)
        StHold: begin
          w_term    = HoldTerm;
          w_cnt_clr = w_tc;
          w_cnt_en  = !w_tc;
        end
        StRel: begin
          w_term    = TimeoutTerm;
          w_cnt_clr = w_ready_cur || w_tc;
          w_cnt_en  = !(w_ready_cur || w_tc);
        end
        StSettle: begin
          w_term    = SettleTerm;
          w_cnt_clr = w_tc;
          w_cnt_en  = !w_tc;
        end
        default: ;
      endcase
    end
  end

  reset_sequencer_delay_counter #(
    .CNT_W (CNT_W)
  ) u_delay_counter (
    .iCLK   (iCLK),
    .iRST   (iRST),
    .i_clr  (w_cnt_clr),
    .i_en   (w_cnt_en),
    .i_term (w_term),
    .o_tc   (w_tc)
  );

  always_ff @(posedge iCLK) begin
    if (iRST || !bus.iSTART) begin
      r_state     <= StIdle;
      r_idx       <= '0;
      r_stage_rst <= '1;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      case (r_state)
        StIdle: r_state <= StHold;
        StHold: begin
          if (w_tc) begin
            r_state        <= StRel;
            r_idx          <= '0;
            r_stage_rst[0] <= 1'b0;
          end
        end
        StRel: begin
          // Ready is checked first so it wins over a coincident timeout.
          if (w_ready_cur) begin
            r_state <= StSettle;
          end else if (w_tc) begin
            r_state     <= StFault;
            r_stage_rst <= '1;
            r_done      <= 1'b0;
            r_error     <= 1'b1;
          end
        end
        StSettle: begin
          if (w_tc) begin
            if (r_idx == LastIdx) begin
              r_state <= StDone;
              r_done  <= 1'b1;
            end else begin
              r_state     <= StRel;
              r_idx       <= w_idx_next;
              r_stage_rst <= r_stage_rst & ~w_next_mask;
            end
          end
        end
        StDone: begin
          if (!(&bus.iREADY)) begin
            r_state     <= StFault;
            r_stage_rst <= '1;
            r_done      <= 1'b0;
            r_error     <= 1'b1;
          end
        end
        StFault: ;
        default: r_state <= StIdle;
      endcase
    end
  end

  assign bus.oSTAGE_RST = r_stage_rst;
  assign bus.oDONE      = r_done;
  assign bus.oERROR     = r_error;
  assign bus.oSTATE     = r_state;

endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: table vectors, hand-written corner sequences and a randomized run
// checked against an event-level model of the sequencer (stages released, time in phase).
module tb_reset_sequencer;

  localparam int unsigned NS      = 3;
  localparam int unsigned HOLD    = 4;
  localparam int unsigned SETTLE  = 2;
  localparam int unsigned TIMEOUT = 8;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  reset_sequencer_if #(.NUM_STAGES(NS)) bus ();

  reset_sequencer #(
    .NUM_STAGES     (NS),
    .CNT_W          (20),
    .HOLD_CYCLES    (HOLD),
    .SETTLE_CYCLES  (SETTLE),
    .TIMEOUT_CYCLES (TIMEOUT)
  ) dut (
    .iCLK (clk),
    .iRST (rst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       start;
    logic [2:0] rdy;
    logic [2:0] e_rst;
    logic       e_done;
    logic       e_err;
    logic [2:0] e_st;
  } vec_t;

  vec_t vecs[20];

  function automatic logic [7:0] pk(input logic [2:0] sr, input logic d, input logic e,
                                    input logic [2:0] st);
    return {sr, d, e, st};
  endfunction

  task automatic tick(input logic r, input logic s, input logic [2:0] rdy);
    rst         = r;
    bus.iSTART  = s;
    bus.iREADY  = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] exp);
    logic [7:0] act;
    act = {bus.oSTAGE_RST, bus.oDONE, bus.oERROR, bus.oSTATE};
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got rst=%b done=%b err=%b state=%0d, want rst=%b done=%b err=%b state=%0d",
               name, act[7:5], act[4], act[3], act[2:0], exp[7:5], exp[4], exp[3], exp[2:0]);
    end
  endtask

  // Event-level model: running/fault flags, number of stages released, whether the
  // newest stage has acked, and edges spent in the current phase.
  bit m_running, m_fault, m_acked, m_done;
  int m_released, m_t;

  task automatic model_step(input logic r, input logic s, input logic [2:0] rdy);
    if (r || !s) begin
      m_running = 0; m_fault = 0; m_acked = 0; m_done = 0; m_released = 0; m_t = 0;
    end else if (m_fault) begin
    end else if (!m_running) begin
      m_running = 1; m_t = 0;
    end else if (m_released == 0) begin
      m_t++;
      if (m_t == HOLD) begin m_released = 1; m_t = 0; end
    end else if (m_done) begin
      if (rdy != 3'b111) begin m_fault = 1; m_done = 0; end
    end else if (!m_acked) begin
      if (rdy[m_released-1]) begin
        m_acked = 1; m_t = 0;
      end else begin
        m_t++;
        if (m_t == TIMEOUT) m_fault = 1;
      end
    end else begin
      m_t++;
      if (m_t == SETTLE) begin
        if (m_released == NS) m_done = 1;
        else begin m_released++; m_acked = 0; m_t = 0; end
      end
    end
  endtask

  function automatic logic [7:0] model_exp();
    logic [2:0] sr;
    logic [2:0] st;
    sr = 3'b111;
    if (m_running && !m_fault)
      for (int k = 0; k < m_released; k++) sr[k] = 1'b0;
    if (!m_running)           st = 3'd0;
    else if (m_fault)         st = 3'd5;
    else if (m_released == 0) st = 3'd1;
    else if (m_done)          st = 3'd4;
    else if (!m_acked)        st = 3'd2;
    else                      st = 3'd3;
    return {sr, m_done, m_fault && m_running, st};
  endfunction

  // Reset, start, and run the hold interval so stage 0 has just been released.
  task automatic go_rel0();
    tick(1'b1, 1'b0, 3'b000);
    tick(1'b0, 1'b1, 3'b000);
    repeat (HOLD) tick(1'b0, 1'b1, 3'b000);
    chk("rel0", pk(3'b110, 1'b0, 1'b0, 3'd2));
  endtask

  initial begin
    logic       r, s;
    logic [2:0] rdy;
    int unsigned thr;
    total = 0;
    bad   = 0;
    rst        = 1'b1;
    bus.iSTART = 1'b0;
    bus.iREADY = '0;

    // Reset, full bring-up, then loss of ready in DONE and recovery by reset.
    vecs[0]  = '{1'b1, 1'b0, 3'b000, 3'b111, 1'b0, 1'b0, 3'd0};
    vecs[1]  = '{1'b1, 1'b0, 3'b000, 3'b111, 1'b0, 1'b0, 3'd0};
    vecs[2]  = '{1'b0, 1'b1, 3'b000, 3'b111, 1'b0, 1'b0, 3'd1};
    vecs[3]  = '{1'b0, 1'b1, 3'b111, 3'b111, 1'b0, 1'b0, 3'd1};
    vecs[4]  = '{1'b0, 1'b1, 3'b000, 3'b111, 1'b0, 1'b0, 3'd1};
    vecs[5]  = '{1'b0, 1'b1, 3'b000, 3'b111, 1'b0, 1'b0, 3'd1};
    vecs[6]  = '{1'b0, 1'b1, 3'b000, 3'b110, 1'b0, 1'b0, 3'd2};
    vecs[7]  = '{1'b0, 1'b1, 3'b001, 3'b110, 1'b0, 1'b0, 3'd3};
    vecs[8]  = '{1'b0, 1'b1, 3'b000, 3'b110, 1'b0, 1'b0, 3'd3};
    vecs[9]  = '{1'b0, 1'b1, 3'b001, 3'b100, 1'b0, 1'b0, 3'd2};
    vecs[10] = '{1'b0, 1'b1, 3'b011, 3'b100, 1'b0, 1'b0, 3'd3};
    vecs[11] = '{1'b0, 1'b1, 3'b011, 3'b100, 1'b0, 1'b0, 3'd3};
    vecs[12] = '{1'b0, 1'b1, 3'b011, 3'b000, 1'b0, 1'b0, 3'd2};
    vecs[13] = '{1'b0, 1'b1, 3'b111, 3'b000, 1'b0, 1'b0, 3'd3};
    vecs[14] = '{1'b0, 1'b1, 3'b111, 3'b000, 1'b0, 1'b0, 3'd3};
    vecs[15] = '{1'b0, 1'b1, 3'b111, 3'b000, 1'b1, 1'b0, 3'd4};
    vecs[16] = '{1'b0, 1'b1, 3'b111, 3'b000, 1'b1, 1'b0, 3'd4};
    vecs[17] = '{1'b0, 1'b1, 3'b011, 3'b111, 1'b0, 1'b1, 3'd5};
    vecs[18] = '{1'b0, 1'b1, 3'b111, 3'b111, 1'b0, 1'b1, 3'd5};
    vecs[19] = '{1'b1, 1'b1, 3'b111, 3'b111, 1'b0, 1'b0, 3'd0};

    for (int i = 0; i < 20; i++) begin
      tick(vecs[i].rst, vecs[i].start, vecs[i].rdy);
      chk($sformatf("vec%0d", i),
          pk(vecs[i].e_rst, vecs[i].e_done, vecs[i].e_err, vecs[i].e_st));
    end

    // Stage 1 never acks: fault exactly TIMEOUT edges after its release.
    go_rel0();
    repeat (SETTLE + 1) tick(1'b0, 1'b1, 3'b001);
    chk("to_rel1", pk(3'b100, 1'b0, 1'b0, 3'd2));
    repeat (TIMEOUT - 1) tick(1'b0, 1'b1, 3'b001);
    chk("to_before", pk(3'b100, 1'b0, 1'b0, 3'd2));
    tick(1'b0, 1'b1, 3'b001);
    chk("to_fault", pk(3'b111, 1'b0, 1'b1, 3'd5));

    // Ready arriving on the timeout edge wins.
    go_rel0();
    repeat (TIMEOUT - 1) tick(1'b0, 1'b1, 3'b000);
    chk("edge_wait", pk(3'b110, 1'b0, 1'b0, 3'd2));
    tick(1'b0, 1'b1, 3'b001);
    chk("edge_ready", pk(3'b110, 1'b0, 1'b0, 3'd3));

    // Abort in stage 1 settle, then retry from HOLD.
    go_rel0();
    repeat (SETTLE + 1) tick(1'b0, 1'b1, 3'b001);
    tick(1'b0, 1'b1, 3'b011);
    chk("ab_settle1", pk(3'b100, 1'b0, 1'b0, 3'd3));
    tick(1'b0, 1'b0, 3'b011);
    chk("ab_idle", pk(3'b111, 1'b0, 1'b0, 3'd0));
    tick(1'b0, 1'b1, 3'b000);
    chk("ab_hold", pk(3'b111, 1'b0, 1'b0, 3'd1));
    repeat (HOLD - 1) tick(1'b0, 1'b1, 3'b111);
    chk("ab_hold_end", pk(3'b111, 1'b0, 1'b0, 3'd1));
    tick(1'b0, 1'b1, 3'b000);
    chk("ab_rel0", pk(3'b110, 1'b0, 1'b0, 3'd2));

    // Reset mid-sequence.
    go_rel0();
    tick(1'b0, 1'b1, 3'b001);
    tick(1'b1, 1'b1, 3'b001);
    chk("mid_rst", pk(3'b111, 1'b0, 1'b0, 3'd0));

    // Randomized run against the model.
    tick(1'b1, 1'b0, 3'b000);
    model_step(1'b1, 1'b0, 3'b000);
    thr = 8;
    for (int c = 0; c < 4000; c++) begin
      if (c % 64 == 0) thr = $urandom_range(5, 10);
      r   = ($urandom_range(0, 199) == 0);
      s   = ($urandom_range(0, 59) != 0);
      rdy = ($urandom_range(0, 9) < thr) ? 3'b111 : 3'($urandom_range(0, 7));
      tick(r, s, rdy);
      model_step(r, s, rdy);
      chk("random", model_exp());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
